// File: rtl/fc_pkg.sv
// Shared types and default sizes for the FC-output argmax classifier.
package fc_pkg;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned SCORE_W_DEF     = 38;
  localparam int unsigned IDX_W_DEF       = 4;

  typedef logic signed [SCORE_W_DEF-1:0] score_t;
  typedef logic        [IDX_W_DEF-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DRAIN
  } fc_argmax_state_e;

endpackage

// File: rtl/fc_score_cmp.sv
// Signed compare/update of the running maximum against one candidate score.
// With FC_ARGMAX_MARGIN_EN defined, the runner-up score is tracked as well.
module fc_score_cmp
  import fc_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic signed [SCORE_W-1:0] best_i,
  input  logic        [IDX_W-1:0]   idx_i,
`ifdef FC_ARGMAX_MARGIN_EN
  input  logic signed [SCORE_W-1:0] second_i,
  output logic signed [SCORE_W-1:0] second_o,
`endif
  input  logic signed [SCORE_W-1:0] cand_i,
  input  logic        [IDX_W-1:0]   cand_idx_i,
  output logic signed [SCORE_W-1:0] best_o,
  output logic        [IDX_W-1:0]   idx_o
);

  // Strictly-greater replaces the best, so ties keep the lower index.
  always_comb begin
    best_o = best_i;
    idx_o  = idx_i;
`ifdef FC_ARGMAX_MARGIN_EN
    second_o = second_i;
`endif
    if (cand_i > best_i) begin
      best_o = cand_i;
      idx_o  = cand_idx_i;
`ifdef FC_ARGMAX_MARGIN_EN
      second_o = best_i;
`endif
    end
`ifdef FC_ARGMAX_MARGIN_EN
    else if (cand_i > second_i) begin
      second_o = cand_i;
    end
`endif
  end

endmodule

// File: rtl/fc_argmax.sv
// Argmax over the ten FC output neurons: capture all scores once every neuron
// is done, scan them one per cycle, hold the winner on a valid/ready handshake.
// Optional macro FC_ARGMAX_MARGIN_EN adds the best-minus-runner-up margin port.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CLASSES-1:0]         done_vec,
  input  logic [NUM_CLASSES*SCORE_W-1:0] score_flat,
  input  logic                           out_ready,
`ifdef FC_ARGMAX_MARGIN_EN
  output logic [SCORE_W:0]               margin,
`endif
  output logic                           out_valid,
  output logic [IDX_W-1:0]               class_idx,
  output logic signed [SCORE_W-1:0]      max_score,
  output logic                           busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  fc_argmax_state_e          state_q, state_d;
  logic signed [SCORE_W-1:0] bank_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0] bank_d [NUM_CLASSES];
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      done_all_q;
  logic                      out_valid_q, out_valid_d;
  logic [IDX_W-1:0]          class_idx_q, class_idx_d;
  logic signed [SCORE_W-1:0] max_score_q, max_score_d;
  logic                      busy_q, busy_d;
  logic signed [SCORE_W-1:0] cmp_best;
  logic [IDX_W-1:0]          cmp_idx;
`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second_q, second_d;
  logic signed [SCORE_W-1:0] cmp_second;
  logic [SCORE_W:0]          margin_q, margin_d;
`endif

  // Single comparator shared across all scan cycles.
  fc_score_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_cmp (
    .best_i     (best_q),
    .idx_i      (idx_q),
`ifdef FC_ARGMAX_MARGIN_EN
    .second_i   (second_q),
    .second_o   (cmp_second),
`endif
    .cand_i     (bank_q[ptr_q]),
    .cand_idx_i (ptr_q),
    .best_o     (cmp_best),
    .idx_o      (cmp_idx)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    ptr_d       = ptr_q;
    best_d      = best_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
`ifdef FC_ARGMAX_MARGIN_EN
    second_d = second_q;
    margin_d = margin_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (done_all_q) begin
          for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            bank_d[k] = score_flat[k*SCORE_W +: SCORE_W];
          end
          best_d  = score_flat[SCORE_W-1:0];
          idx_d   = '0;
          ptr_d   = IDX_W'(1);
`ifdef FC_ARGMAX_MARGIN_EN
          // Most negative value: any candidate ties or beats it.
          second_d = {1'b1, {(SCORE_W-1){1'b0}}};
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        best_d = cmp_best;
        idx_d  = cmp_idx;
`ifdef FC_ARGMAX_MARGIN_EN
        second_d = cmp_second;
`endif
        if (ptr_q == LAST_IDX) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          class_idx_d = cmp_idx;
          max_score_d = cmp_best;
`ifdef FC_ARGMAX_MARGIN_EN
          // One extra bit so best - second cannot overflow.
          margin_d = {cmp_best[SCORE_W-1], cmp_best} - {cmp_second[SCORE_W-1], cmp_second};
`endif
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (~|done_vec) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the done flags to drop so a frame is classified only once.
        if (~|done_vec) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == HOLD);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        bank_q[k] <= '0;
      end
      ptr_q       <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      done_all_q  <= 1'b0;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      max_score_q <= '0;
      busy_q      <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      ptr_q       <= ptr_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      done_all_q  <= &done_vec;
      out_valid_q <= out_valid_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
      busy_q      <= busy_d;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
  assign busy      = busy_q;
`ifdef FC_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: stimulus pushes expected results, a monitor
// pops and checks them (index, score, margin, latency, hold stability).
module tb_fc_argmax;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 38;
  localparam int unsigned IW = 4;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          done_vec;
  logic [N*W-1:0]        score_flat;
  logic                  out_ready;
  logic                  out_valid;
  logic [IW-1:0]         class_idx;
  logic signed [W-1:0]   max_score;
  logic                  busy;
`ifdef FC_ARGMAX_MARGIN_EN
  logic [W:0]            margin;
`endif

  typedef struct {
    int         idx;
    longint     score;
    longint     marg;
    longint     rise;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  bit     seen;
  longint cyc;
  int     checks;
  int     errors;
  logic signed [W-1:0] sc [N];

  fc_argmax u_dut (
    .clk        (clk),
    .rst        (rst),
    .done_vec   (done_vec),
    .score_flat (score_flat),
    .out_ready  (out_ready),
`ifdef FC_ARGMAX_MARGIN_EN
    .margin     (margin),
`endif
    .out_valid  (out_valid),
    .class_idx  (class_idx),
    .max_score  (max_score),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the largest of the rest.
  function automatic exp_t model();
    exp_t   e;
    longint v [N];
    int     bi;
    longint sec;
    for (int k = 0; k < N; k++) v[k] = sc[k];
    bi = 0;
    for (int k = 1; k < N; k++) if (v[k] > v[bi]) bi = k;
    sec = -(longint'(1) << (W - 1));
    for (int k = 0; k < N; k++) if (k != bi && v[k] > sec) sec = v[k];
    e.idx   = bi;
    e.score = v[bi];
    e.marg  = v[bi] - sec;
    e.rise  = 0;
    return e;
  endfunction

  // Monitor: pop on each new result, then require it to stay stable while held.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: idx %0d score %0d with no result pending", class_idx, max_score);
          cur.idx = int'(class_idx); cur.score = max_score; cur.marg = 0; cur.rise = cyc;
        end else begin
          cur = exp_q.pop_front();
          chk("latency", cyc, cur.rise);
          chk("class_idx", longint'(class_idx), longint'(cur.idx));
          chk("max_score", longint'(max_score), cur.score);
`ifdef FC_ARGMAX_MARGIN_EN
          chk("margin", longint'(margin), cur.marg);
`endif
          chk("busy_hold", longint'(busy), 1);
        end
        seen = 1'b1;
      end else begin
        chk("hold_idx", longint'(class_idx), longint'(cur.idx));
        chk("hold_score", longint'(max_score), cur.score);
`ifdef FC_ARGMAX_MARGIN_EN
        chk("hold_margin", longint'(margin), cur.marg);
`endif
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic load_scores();
    for (int k = 0; k < N; k++) score_flat[k*W +: W] = sc[k];
  endtask

  // One frame: present scores, raise done, wait, hold, accept, release done.
  task automatic issue(input int hold_cycles, input bit drop_done);
    exp_t e;
    int   n;
    load_scores();
    e = model();
    e.rise = cyc + N + 1;
    exp_q.push_back(e);
    done_vec = '1;
    n = 0;
    while (!out_valid && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("valid_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    score_flat = {12{$urandom}};
    repeat (hold_cycles) @(negedge clk);
    out_ready = 1'b1;
    if (drop_done) done_vec = '0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_accept", longint'(out_valid), 0);
    if (!drop_done) begin
      n = 0;
      repeat (6) begin
        @(negedge clk);
        if (out_valid || busy) n++;
      end
      chk("drain_no_result", n, 0);
      done_vec = '0;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    longint mn;
    int     n;
    cyc = 0; checks = 0; errors = 0; seen = 1'b0;
    rst = 1'b1; done_vec = '0; out_ready = 1'b0; score_flat = '0;
    mn = -(longint'(1) << (W - 1));
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_idx", longint'(class_idx), 0);
    chk("rst_score", longint'(max_score), 0);
    chk("rst_busy", longint'(busy), 0);
`ifdef FC_ARGMAX_MARGIN_EN
    chk("rst_margin", longint'(margin), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Ascending scores, long hold with done still high (drain path).
    for (int k = 0; k < N; k++) sc[k] = W'(longint'(k) * 100);
    issue(20, 1'b0);

    // Single positive outlier.
    for (int k = 0; k < N; k++) sc[k] = -38'sd5;
    sc[3] = 38'sd7;
    issue(0, 1'b1);

    // All equal: lowest index wins, zero margin.
    for (int k = 0; k < N; k++) sc[k] = 38'sd42;
    issue(2, 1'b1);

    // Most negative value present, remaining tie near the bottom.
    for (int k = 0; k < N; k++) sc[k] = W'(mn + 1);
    sc[6] = W'(mn);
    issue(1, 1'b0);

    // Missing one done flag: nothing may happen.
    for (int k = 0; k < N; k++) sc[k] = W'(longint'($urandom_range(0, 1000)) - 500);
    load_scores();
    done_vec = N'(10'h1FF);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid || busy) n++;
    end
    chk("partial_done_idle", n, 0);
    issue(0, 1'b1);

    // Reset in the middle of a scan: the result is discarded.
    for (int k = 0; k < N; k++) sc[k] = W'({$urandom, $urandom});
    load_scores();
    done_vec = '1;
    repeat (6) @(negedge clk);
    chk("busy_scan", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_idx", longint'(class_idx), 0);
    chk("midrst_score", longint'(max_score), 0);
    rst = 1'b0;
    done_vec = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) sc[k] = W'(longint'(k * 7 % 10) * 3 - 11);
    issue(0, 1'b1);

    // Randomized frames, some with heavy ties.
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < N; k++) begin
        if (f % 3 == 0) sc[k] = W'(longint'($urandom_range(0, 4)) - 2);
        else            sc[k] = W'({$urandom, $urandom});
      end
      issue(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
